// File: rtl/prng_range_sampler.sv
// prng_range_sampler: converts a raw 1..15 LFSR stream into an unbiased value in
// [0, N-1] using rejection sampling followed by iterative modulo reduction.
module prng_range_sampler #(
    parameter int unsigned MAX_TRIES = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rnd_in,
    input  logic       rnd_valid,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_range,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_value,
    output logic       out_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q;
    logic [3:0]         n_q;
    logic [3:0]         work_q;
    logic [3:0]         out_value_q;
    logic [CNT_W-1:0]   tries_q;
    logic               req_ready_q;
    logic               out_valid_q;
    logic               out_err_q;

    logic [3:0]         lim_c;
    logic               accept_c;
    logic [CNT_W-1:0]   tries_d;

    // Largest multiple of N that fits in 1..15; samples above it would bias the result.
    always_comb begin
        lim_c = 4'd15;
        case (n_q)
            4'd1:    lim_c = 4'd15;
            4'd2:    lim_c = 4'd14;
            4'd3:    lim_c = 4'd15;
            4'd4:    lim_c = 4'd12;
            4'd5:    lim_c = 4'd15;
            4'd6:    lim_c = 4'd12;
            4'd7:    lim_c = 4'd14;
            4'd8:    lim_c = 4'd8;
            4'd9:    lim_c = 4'd9;
            4'd10:   lim_c = 4'd10;
            4'd11:   lim_c = 4'd11;
            4'd12:   lim_c = 4'd12;
            4'd13:   lim_c = 4'd13;
            4'd14:   lim_c = 4'd14;
            4'd15:   lim_c = 4'd15;
            default: lim_c = 4'd15;
        endcase
    end

    // Zero never comes from the LFSR, so it is treated as an invalid sample.
    assign accept_c = (rnd_in != 4'd0) && (rnd_in <= lim_c);
    assign tries_d  = tries_q + CNT_W'(1);

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            n_q         <= 4'd0;
            work_q      <= 4'd0;
            out_value_q <= 4'd0;
            tries_q     <= '0;
            req_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        n_q         <= req_range;
                        tries_q     <= '0;
                        req_ready_q <= 1'b0;
                        if (req_range == 4'd0) begin
                            out_value_q <= 4'd0;
                            out_err_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= SAMPLE;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (rnd_valid) begin
                        if (accept_c) begin
                            work_q  <= rnd_in - 4'd1;
                            state_q <= REDUCE;
                        end else begin
                            tries_q <= tries_d;
                            if (tries_d == CNT_W'(MAX_TRIES)) begin
                                out_value_q <= 4'd0;
                                out_err_q   <= 1'b1;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
                        end
                    end
                end
                REDUCE: begin
                    if (work_q >= n_q) begin
                        work_q <= work_q - n_q;
                    end else begin
                        out_value_q <= work_q;
                        out_err_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_err   = out_err_q;

endmodule
